// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: one instruction per handshake, load/store via
// a req/ack data-memory port, registered single-cycle register-file write pulse.
module mem_wb_stage (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_result_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_reg_write_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mem_write_i,
  input  logic [2:0]  ex_funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wmask_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        RegWrite_o,
  output logic [4:0]  RD_address_o,
  output logic [31:0] RD_data_o,
  output logic        fault_o
);

  // state    | meaning
  // IDLE     | ready to accept; ALU results and faults retire from here
  // WAIT_MEM | memory request outstanding until dmem_ack_i
  typedef enum logic {IDLE, WAIT_MEM} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        we_q, we_d;
  logic        load_q, load_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        fault_q, fault_d;

  logic        is_mem, illegal, misaligned;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  assign is_mem  = ex_mem_read_i | ex_mem_write_i;
  assign illegal = (ex_funct3_i[1:0] == 2'b11)
                 | (ex_funct3_i[2] & (ex_funct3_i[1:0] == 2'b10))
                 | (ex_funct3_i[2] & ex_mem_write_i);
  assign misaligned = ((ex_funct3_i[1:0] == 2'b01) & ex_result_i[0])
                    | ((ex_funct3_i[1:0] == 2'b10) & (ex_result_i[1:0] != 2'b00));

  always_comb begin
    st_mask = 4'b1111;
    st_data = ex_store_data_i;
    case (ex_funct3_i[1:0])
      2'b00: begin
        st_mask = 4'b0001 << ex_result_i[1:0];
        st_data = {4{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << ex_result_i[1:0];
        st_data = {2{ex_store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    we_d       = we_q;
    load_d     = load_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    regwrite_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    fault_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (!is_mem) begin
            regwrite_d = ex_reg_write_i & (ex_rd_i != 5'd0);
            rd_addr_d  = ex_rd_i;
            rd_data_d  = ex_result_i;
          end else if (illegal || misaligned) begin
            fault_d = 1'b1;
          end else begin
            addr_d   = ex_result_i[31:2];
            off_d    = ex_result_i[1:0];
            wdata_d  = st_data;
            wmask_d  = st_mask;
            we_d     = ex_mem_write_i;
            load_d   = ex_mem_read_i;
            rd_d     = ex_rd_i;
            funct3_d = ex_funct3_i;
            state_d  = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (dmem_ack_i) begin
          state_d    = IDLE;
          regwrite_d = load_q & (rd_q != 5'd0);
          if (load_q) begin
            rd_addr_d = rd_q;
            rd_data_d = ld_value;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      we_q       <= 1'b0;
      load_q     <= 1'b0;
      rd_q       <= '0;
      funct3_q   <= '0;
      regwrite_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      we_q       <= we_d;
      load_q     <= load_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      regwrite_q <= regwrite_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      fault_q    <= fault_d;
    end
  end

  // Request is decoded from the state register so it drops as soon as reset hits.
  assign ex_ready_o   = (state_q == IDLE);
  assign dmem_req_o   = (state_q == WAIT_MEM);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q, 2'b00};
  assign dmem_wdata_o = wdata_q;
  assign dmem_wmask_o = wmask_q;
  assign RegWrite_o   = regwrite_q;
  assign RD_address_o = rd_addr_q;
  assign RD_data_o    = rd_data_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage: a cycle-stamped event scoreboard built from the
// access rules (legality, lanes, extraction) is compared against the DUT every cycle.
module tb_mem_wb_stage;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] ex_result_i = '0;
  logic [31:0] ex_store_data_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        ex_reg_write_i = 1'b0;
  logic        ex_mem_read_i = 1'b0;
  logic        ex_mem_write_i = 1'b0;
  logic [2:0]  ex_funct3_i = '0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wmask_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        RegWrite_o;
  logic [4:0]  RD_address_o;
  logic [31:0] RD_data_o;
  logic        fault_o;

  mem_wb_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_result_i(ex_result_i), .ex_store_data_i(ex_store_data_i),
    .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
    .ex_funct3_i(ex_funct3_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .RegWrite_o(RegWrite_o), .RD_address_o(RD_address_o), .RD_data_o(RD_data_o),
    .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {int c; bit is_fault; logic [4:0] rd; logic [31:0] data;} ev_t;
  ev_t q[$];
  bit          req_exp = 1'b0;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_mask;
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input logic [2:0] f3, input bit st, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b0;
    if (st && f3 >= 4) return 1'b0;
    return (int'(a[1:0]) % m_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = ((1 << m_size(f3)) - 1) << a[1:0];
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (m_size(f3) == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] r);
    logic [63:0] v;
    int sz;
    sz = m_size(f3);
    if (sz == 4) return r;
    v = ({32'd0, r} >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
    if (f3[2] == 1'b0 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  // Per-cycle comparison against the scoreboard and the expected request.
  always @(negedge clk_i) begin
    bit exp_wb, exp_f;
    while (q.size() > 0 && q[0].c < cyc) begin
      total++; bad++;
      $display("FAIL missed_event actual=none required=cycle%0d now=%0d", q[0].c, cyc);
      void'(q.pop_front());
    end
    exp_wb = 1'b0;
    exp_f  = 1'b0;
    if (q.size() > 0 && q[0].c == cyc) begin
      if (q[0].is_fault) exp_f = 1'b1;
      else exp_wb = 1'b1;
    end
    chk("regwrite", RegWrite_o, exp_wb);
    chk("fault", fault_o, exp_f);
    if (exp_wb && RegWrite_o) begin
      chk("rd_address", RD_address_o, q[0].rd);
      chk("rd_data", RD_data_o, q[0].data);
    end
    if (exp_wb || exp_f) void'(q.pop_front());
    chk("dmem_req", dmem_req_o, req_exp);
    chk("ex_ready", ex_ready_o, !req_exp);
    if (req_exp && dmem_req_o) begin
      chk("dmem_we", dmem_we_o, req_we);
      chk("dmem_addr", dmem_addr_o, req_addr);
      if (req_we) begin
        chk("dmem_wdata", dmem_wdata_o, req_wdata);
        chk("dmem_wmask", dmem_wmask_o, req_mask);
      end
    end
  end

  // kind: 0 ALU, 1 load, 2 store. Called at posedge+2; w = memory wait cycles.
  task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] res,
                       input logic [31:0] sd, input logic [4:0] rd, input bit rw,
                       input int w, input logic [31:0] rdata);
    int k;
    bit legal;
    k = cyc;
    legal = m_legal(f3, kind == 2, res);
    ex_valid_i = 1'b1;
    ex_result_i = res; ex_store_data_i = sd; ex_rd_i = rd; ex_reg_write_i = rw;
    ex_mem_read_i = (kind == 1); ex_mem_write_i = (kind == 2); ex_funct3_i = f3;
    if (kind == 0) begin
      if (rw && rd != 0) q.push_back('{k + 1, 1'b0, rd, res});
    end else if (!legal) begin
      q.push_back('{k + 1, 1'b1, 5'd0, 32'd0});
    end
    @(posedge clk_i); #2;
    ex_valid_i = 1'b0;
    ex_result_i = $urandom; ex_store_data_i = $urandom; ex_rd_i = 5'($urandom);
    if (kind != 0 && legal) begin
      req_exp = 1'b1; req_we = (kind == 2); req_addr = res & ~32'd3;
      req_wdata = m_wdata(f3, sd); req_mask = m_mask(f3, res);
      repeat (w) begin @(posedge clk_i); #2; end
      dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
      if (kind == 1 && rd != 0) q.push_back('{cyc + 1, 1'b0, rd, m_load(f3, res[1:0], rdata)});
      @(posedge clk_i); #2;
      dmem_ack_i = 1'b0; req_exp = 1'b0; dmem_rdata_i = $urandom;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      dmem_ack_i = 1'($urandom); dmem_rdata_i = $urandom;
      @(posedge clk_i); #2;
    end
    dmem_ack_i = 1'b0;
  endtask

  initial begin
    #1 rst_n_i = 1'b0;
    #1;
    chk("reset_req", dmem_req_o, 0);
    chk("reset_regwrite", RegWrite_o, 0);
    chk("reset_rd_address", RD_address_o, 0);
    chk("reset_rd_data", RD_data_o, 0);
    chk("reset_fault", fault_o, 0);
    chk("reset_ready", ex_ready_o, 1);
    chk("pin_lb", m_load(3'b000, 2'd3, 32'h80AA_BBCC), 32'hFFFF_FF80);
    chk("pin_lbu", m_load(3'b100, 2'd3, 32'h80AA_BBCC), 32'h0000_0080);
    chk("pin_sh_mask", m_mask(3'b001, 32'h202), 4'b1100);
    chk("pin_sh_wdata", m_wdata(3'b001, 32'h1234_ABCD), 32'hABCD_ABCD);
    chk("pin_lw_misaligned", m_legal(3'b010, 1'b0, 32'h301), 0);
    chk("pin_sbu_illegal", m_legal(3'b100, 1'b1, 32'h300), 0);
    repeat (2) @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    @(posedge clk_i); #2;

    issue(0, 3'b000, 32'h0000_1234, 0, 5'd5, 1, 0, 0);
    idle(2);
    issue(1, 3'b000, 32'h103, 0, 5'd6, 1, 3, 32'h80AA_BBCC);
    issue(1, 3'b100, 32'h103, 0, 5'd6, 1, 3, 32'h80AA_BBCC);
    issue(2, 3'b001, 32'h202, 32'h1234_ABCD, 5'd9, 0, 1, 0);
    issue(1, 3'b010, 32'h301, 0, 5'd4, 1, 0, 0);
    issue(2, 3'b100, 32'h300, 32'h55, 5'd4, 0, 0, 0);
    issue(1, 3'b010, 32'h400, 0, 5'd0, 1, 1, 32'hDEAD_BEEF);
    issue(0, 3'b000, 32'hCAFE_0001, 0, 5'd31, 1, 0, 0);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(0, 2), 3'($urandom), $urandom, $urandom, 5'($urandom),
            1'($urandom), $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Reset while a load is outstanding.
    issue(0, 3'b000, 32'h7777_0000, 0, 5'd3, 1, 0, 0);
    ex_valid_i = 1'b1; ex_result_i = 32'h400; ex_rd_i = 5'd7; ex_reg_write_i = 1'b1;
    ex_mem_read_i = 1'b1; ex_mem_write_i = 1'b0; ex_funct3_i = 3'b010;
    @(posedge clk_i); #2;
    ex_valid_i = 1'b0;
    req_exp = 1'b1; req_we = 1'b0; req_addr = 32'h400;
    @(posedge clk_i); #2;
    rst_n_i = 1'b0;
    #1;
    chk("reset_drops_req", dmem_req_o, 0);
    chk("reset_clears_rd_data", RD_data_o, 0);
    req_exp = 1'b0;
    @(posedge clk_i); #2;
    rst_n_i = 1'b1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    @(posedge clk_i); #2;
    dmem_ack_i = 1'b0;
    chk("ready_after_reset", ex_ready_o, 1);
    issue(0, 3'b000, 32'h0BAD_F00D, 0, 5'd12, 1, 0, 0);
    idle(3);
    chk("events_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
